// File: rtl/fetch32_if.sv
// fetch32_if: instruction memory req/ack bus.
// master (fetch) drives imreq/imaddr; slave (memory) drives imack/imdata.
interface fetch32_if;
  logic        imreq;
  logic [31:0] imaddr;
  logic        imack;
  logic [31:0] imdata;

  modport master (
    output imreq,
    output imaddr,
    input  imack,
    input  imdata
  );

  modport slave (
    input  imreq,
    input  imaddr,
    output imack,
    output imdata
  );
endinterface

// File: rtl/fetch32.sv
// fetch32: fetch stage between PC and decode, one memory request in flight,
// DEPTH-entry instruction queue, flush kills queue and in-flight response.
// Ports: clk, rst_n (sync, active low); pcaddr in / pcstall out (PC side);
// flush in; im (fetch32_if.master: imreq/imaddr out, imack/imdata in);
// insn/insnaddr/insnvalid out, insnready in (decode side).
// FETCH32_PERF_EN adds perfstall[31:0] and perfflush[15:0] counters.
module fetch32 #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pcaddr,
  output logic        pcstall,
  input  logic        flush,
  fetch32_if.master   im,
  output logic [31:0] insn,
  output logic [31:0] insnaddr,
  output logic        insnvalid,
  input  logic        insnready
`ifdef FETCH32_PERF_EN
  ,
  output logic [31:0] perfstall,
  output logic [15:0] perfflush
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DISCARD
  } state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } entry_t;

  state_t        state;
  entry_t        q [DEPTH];
  logic [AW-1:0] rdptr;
  logic [AW-1:0] wrptr;
  logic [CW-1:0] count;

  logic room;
  logic accept;
  logic push;
  logic pop;

  assign room   = count < CW'(DEPTH);
  assign accept = (state == IDLE) && !flush && room;
  assign push   = (state == REQ) && im.imack && !flush;
  assign pop    = insnready && (count != '0) && !flush;

  assign pcstall   = !accept;
  assign insnvalid = count != '0;
  assign insn      = q[rdptr].data;
  assign insnaddr  = q[rdptr].addr;

  // Request FSM. A response arriving after a flush is swallowed in
  // DISCARD so it never reaches the queue.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      im.imreq  <= 1'b0;
      im.imaddr <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            im.imaddr <= pcaddr;
            im.imreq  <= 1'b1;
            state     <= REQ;
          end
        end
        REQ: begin
          if (im.imack) begin
            im.imreq <= 1'b0;
            state    <= IDLE;
          end else if (flush) begin
            state <= DISCARD;
          end
        end
        DISCARD: begin
          if (im.imack) begin
            im.imreq <= 1'b0;
            state    <= IDLE;
          end
        end
        default: begin
          im.imreq <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

  // Instruction queue. Accept only when a slot is free, so a later
  // push always has room even with no pop.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rdptr <= '0;
      wrptr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        q[i] <= '0;
      end
    end else if (flush) begin
      rdptr <= '0;
      wrptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q[wrptr] <= {im.imaddr, im.imdata};
        wrptr    <= wrptr + AW'(1);
      end
      if (pop) begin
        rdptr <= rdptr + AW'(1);
      end
      unique case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

`ifdef FETCH32_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      perfstall <= '0;
      perfflush <= '0;
    end else begin
      if (pcstall && (perfstall != '1)) begin
        perfstall <= perfstall + 32'd1;
      end
      if (flush && (perfflush != '1)) begin
        perfflush <= perfflush + 16'd1;
      end
    end
  end
`endif

endmodule
